// File: rtl/noisy_source_pkg.sv
// Shared definitions for the noisy square-wave burst generator.
//   state_t    : FSM state encoding (IDLE, RUN, DONE)
//   W_DEFAULT  : default width of every timing/count configuration input
package noisy_source_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/noisy_source_if.sv
// Control/status bundle of noisy_source.
//   start        : burst request, only looked at while the generator is idle
//   half_period  : cycles per half period (0 behaves as 1)
//   glitch_pos   : offset inside each half period where the glitch begins
//   glitch_len   : glitch width in cycles (0 = no glitch)
//   n_periods    : number of full periods in the burst
//   sig_out      : generated noisy square wave (flop output)
//   busy         : high while a burst is running
//   done         : one-cycle pulse at burst completion
//   state        : current FSM state, exported for observation
// Handshake: start is a level request with no ready; it is accepted on any
// rising edge where the generator is IDLE and start=1, and ignored otherwise
// (never queued). Completion is signalled by the single-cycle done pulse.
interface noisy_source_if #(
  parameter int W = noisy_source_pkg::W_DEFAULT
);
  import noisy_source_pkg::*;

  logic         start;
  logic [W-1:0] half_period;
  logic [W-1:0] glitch_pos;
  logic [W-1:0] glitch_len;
  logic [W-1:0] n_periods;
  logic         sig_out;
  logic         busy;
  logic         done;
  state_t       state;

  modport master (
    output start, half_period, glitch_pos, glitch_len, n_periods,
    input  sig_out, busy, done, state
  );

  modport slave (
    input  start, half_period, glitch_pos, glitch_len, n_periods,
    output sig_out, busy, done, state
  );

endinterface

// File: rtl/noisy_source_glitch_window.sv
// Combinational glitch-window decode.
//   cnt        : position inside the current half period (0..hp-1)
//   glitch_pos : first glitched position
//   glitch_len : glitch width, 0 disables the glitch
//   hp         : effective half-period length (already forced >= 1)
//   active     : high when cnt lies inside the glitch window
module glitch_window #(
  parameter int W = noisy_source_pkg::W_DEFAULT
) (
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] glitch_pos,
  input  logic [W-1:0] glitch_len,
  input  logic [W-1:0] hp,
  output logic         active
);

  // End of the window computed one bit wider so pos+len cannot wrap.
  logic [W:0] win_end;

  always_comb begin
    win_end = {1'b0, glitch_pos} + {1'b0, glitch_len};
    // cnt never reaches hp, so the window is naturally truncated at the
    // half-period boundary; a start position at or beyond hp never matches.
    active  = (glitch_len != '0) &&
              (glitch_pos < hp) &&
              (cnt >= glitch_pos) &&
              ({1'b0, cnt} < win_end);
  end

endmodule

// File: rtl/noisy_source.sv
// Burst generator of a square wave with a programmable glitch in every
// half period.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : control/status bundle (noisy_source_if.slave)
// A start seen in IDLE latches the configuration and runs 2*n_periods half
// periods of hp = max(half_period,1) cycles each; the level toggles at each
// half-period boundary and is inverted inside the glitch window.
module noisy_source
  import noisy_source_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  noisy_source_if.slave      bus
);

  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_W1 = {{W{1'b0}}, 1'b1};

  state_t       state_q, state_n;
  logic [W-1:0] cnt_q, cnt_n;
  logic [W:0]   half_q, half_n;
  logic         level_q, level_n;
  logic [W-1:0] hp_q, hp_n;
  logic [W-1:0] gpos_q, gpos_n;
  logic [W-1:0] glen_q, glen_n;
  logic [W-1:0] np_q, np_n;
  logic         sig_q, sig_n;
  logic [W:0]   last_half;
  logic         active_n;

  // Index of the final half period; W+1 bits so 2*n_periods cannot overflow.
  assign last_half = {np_q, 1'b0} - ONE_W1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      level_q <= 1'b0;
      hp_q    <= '0;
      gpos_q  <= '0;
      glen_q  <= '0;
      np_q    <= '0;
      sig_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      half_q  <= half_n;
      level_q <= level_n;
      hp_q    <= hp_n;
      gpos_q  <= gpos_n;
      glen_q  <= glen_n;
      np_q    <= np_n;
      sig_q   <= sig_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    half_n  = half_q;
    level_n = level_q;
    hp_n    = hp_q;
    gpos_n  = gpos_q;
    glen_n  = glen_q;
    np_n    = np_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          hp_n    = (bus.half_period == '0) ? ONE_W : bus.half_period;
          gpos_n  = bus.glitch_pos;
          glen_n  = bus.glitch_len;
          np_n    = bus.n_periods;
          cnt_n   = '0;
          half_n  = '0;
          level_n = 1'b0;
          state_n = (bus.n_periods != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt_q == hp_q - ONE_W) begin
          cnt_n   = '0;
          level_n = ~level_q;
          half_n  = half_q + ONE_W1;
          if (half_q == last_half) begin
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt_q + ONE_W;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The glitch decode looks at the upcoming counter/config so that sig_out
  // can be registered and still line up with the cycle holding that count.
  glitch_window #(.W(W)) u_glitch_window (
    .cnt        (cnt_n),
    .glitch_pos (gpos_n),
    .glitch_len (glen_n),
    .hp         (hp_n),
    .active     (active_n)
  );

  always_comb begin
    sig_n = (state_n == RUN) && (level_n ^ active_n);
  end

  assign bus.sig_out = sig_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_noisy_source.sv
// Self-checking bench for noisy_source: expected {busy,done,sig_out} triples
// are queued when a burst is started and compared as the DUT produces them.
module tb_noisy_source;
  import noisy_source_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  noisy_source_if #(.W(W)) bus();

  noisy_source #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic       mon_en   = 1'b0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Independent reference: one entry per burst cycle, then the done pulse.
  task automatic push_model(input int hp, input int gp, input int gl, input int n);
    int  h_eff;
    logic act;
    h_eff = (hp == 0) ? 1 : hp;
    for (int h = 0; h < 2 * n; h++) begin
      for (int c = 0; c < h_eff; c++) begin
        act = (gl != 0) && (c >= gp) && (c < gp + gl);
        exp_q.push_back({1'b1, 1'b0, ((h % 2) == 1) ^ act});
      end
    end
    exp_q.push_back(3'b010);
  endtask

  // Literal waveform, MSB first, followed by the done pulse.
  task automatic push_pattern(input logic [31:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      exp_q.push_back({2'b10, bits[i]});
    end
    exp_q.push_back(3'b010);
  endtask

  always @(negedge clock) begin
    if (mon_en && reset) begin
      if (bus.busy || bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {29'd0, bus.busy, bus.done, bus.sig_out}, 32'd0);
        end else begin
          check("burst_out", {29'd0, bus.busy, bus.done, bus.sig_out},
                {29'd0, exp_q.pop_front()});
        end
      end else begin
        check("idle_sig", {31'd0, bus.sig_out}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input int hp, input int gp, input int gl, input int n);
    @(posedge clock);
    #1;
    bus.half_period = hp[W-1:0];
    bus.glitch_pos  = gp[W-1:0];
    bus.glitch_len  = gl[W-1:0];
    bus.n_periods   = n[W-1:0];
    bus.start       = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check("lat_busy", {31'd0, bus.busy}, {31'd0, n != 0});
    check("lat_done", {31'd0, bus.done}, {31'd0, n == 0});
    // Inputs change mid-burst; the latched configuration must be used.
    bus.half_period = W'($urandom_range(0, 255));
    bus.glitch_pos  = W'($urandom_range(0, 255));
    bus.glitch_len  = W'($urandom_range(0, 255));
    bus.n_periods   = W'($urandom_range(0, 255));
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bus.start       = 1'b0;
    bus.half_period = '0;
    bus.glitch_pos  = '0;
    bus.glitch_len  = '0;
    bus.n_periods   = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_sig",   {31'd0, bus.sig_out}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy},    32'd0);
    check("rst_done",  {31'd0, bus.done},    32'd0);
    check("rst_state", 32'(bus.state),       32'(IDLE));
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clock);

    // Plain wave
    push_pattern(32'b0000111100001111, 16);
    drive_start(4, 0, 0, 2);
    wait_drain(100);

    // Glitch inside each half period
    push_pattern(32'b0011000011001111, 16);
    drive_start(8, 2, 2, 1);
    wait_drain(100);

    // Glitch truncated at half-period boundary
    push_pattern(32'b00011110, 8);
    drive_start(4, 3, 5, 1);
    wait_drain(100);

    // half_period 0 behaves as 1
    push_pattern(32'b01, 2);
    drive_start(0, 0, 0, 1);
    wait_drain(100);

    // n_periods 0: straight to done
    exp_q.push_back(3'b010);
    drive_start(4, 1, 1, 0);
    wait_drain(100);

    // glitch_pos >= hp, and pos+len that would wrap at W bits
    push_model(4, 4, 2, 1);
    drive_start(4, 4, 2, 1);
    wait_drain(100);
    push_model(5, 200, 100, 1);
    drive_start(5, 200, 100, 1);
    wait_drain(100);
    push_model(6, 1, 255, 1);
    drive_start(6, 1, 255, 1);
    wait_drain(100);

    // Longest burst count with hp=1
    push_model(1, 0, 0, 255);
    drive_start(1, 0, 0, 255);
    wait_drain(600);

    // Random configurations
    for (int i = 0; i < 8; i++) begin
      int hp, gp, gl, n;
      hp = $urandom_range(0, 6);
      gp = $urandom_range(0, 7);
      gl = $urandom_range(0, 7);
      n  = $urandom_range(0, 3);
      push_model(hp, gp, gl, n);
      drive_start(hp, gp, gl, n);
      wait_drain(200);
    end

    // start held high through a burst: one burst, one idle cycle, next burst
    push_pattern(32'b00110011, 8);
    push_pattern(32'b00110011, 8);
    @(posedge clock);
    #1;
    bus.half_period = 8'd2;
    bus.glitch_pos  = 8'd0;
    bus.glitch_len  = 8'd0;
    bus.n_periods   = 8'd2;
    bus.start       = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!bus.done && k < 40);
    check("hold_done_seen", {31'd0, bus.done}, 32'd1);
    @(negedge clock);
    check("hold_gap_busy", {31'd0, bus.busy}, 32'd0);
    check("hold_gap_done", {31'd0, bus.done}, 32'd0);
    @(negedge clock);
    check("hold_restart_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_drain(100);

    // Reset in the middle of a burst
    push_model(4, 0, 0, 3);
    drive_start(4, 0, 0, 3);
    repeat (5) @(posedge clock);
    #1;
    check("pre_reset_sig",  {31'd0, bus.sig_out}, 32'd1);
    check("pre_reset_busy", {31'd0, bus.busy},    32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_sig",   {31'd0, bus.sig_out}, 32'd0);
    check("mid_rst_busy",  {31'd0, bus.busy},    32'd0);
    check("mid_rst_done",  {31'd0, bus.done},    32'd0);
    check("mid_rst_state", 32'(bus.state),       32'(IDLE));
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("post_rst_done", {31'd0, bus.done}, 32'd0);

    // A fresh start still works after reset
    push_model(3, 1, 1, 1);
    drive_start(3, 1, 1, 1);
    wait_drain(100);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
